seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 224 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith ops and a shift-add multiplier.
// Define SEQ_ALU_DIV_EN to compile in the restoring divider (opcode 9).
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       M,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             ZERO,
  output logic             OF,
  output logic             DZ,
  output logic             ILL
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd9;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             of_q;
  logic             dz_q;
  logic             ill_q;

  // Single-cycle result path, registered at the accepting edge
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] alu_lo_d;
  logic [WIDTH-1:0] alu_hi_d;
  logic             alu_of_d;
  logic             alu_dz_d;
  logic             alu_ill_d;
  logic             alu_zero_d;

  always_comb begin
    sum       = A + B;
    diff      = A - B;
    add_of    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    sub_of    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    alu_lo_d  = '0;
    alu_hi_d  = '0;
    alu_of_d  = 1'b0;
    alu_dz_d  = 1'b0;
    alu_ill_d = 1'b0;
    case (M)
      OP_AND:  alu_lo_d = A & B;
      OP_OR:   alu_lo_d = A | B;
      OP_ADD:  begin alu_lo_d = sum;  alu_of_d = add_of; end
      OP_SUB:  begin alu_lo_d = diff; alu_of_d = sub_of; end
      OP_SLT:  alu_lo_d = WIDTH'(diff[WIDTH-1] ^ sub_of);
      OP_NOTA: alu_lo_d = ~A;
      OP_NOR:  alu_lo_d = ~(A | B);
      OP_XOR:  alu_lo_d = A ^ B;
      OP_MULU: alu_lo_d = '0;
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: begin alu_lo_d = '1; alu_hi_d = A; alu_dz_d = 1'b1; end
`endif
      default: alu_ill_d = 1'b1;
    endcase
    alu_zero_d = (alu_lo_d == '0) && !alu_ill_d;
  end

  // One shift-add step: {acc,work} holds the partial product, multiplier in work
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], work_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring step: acc is the partial remainder, work shifts dividend out and quotient in
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;

  always_comb begin
    div_shift = {acc_q, work_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem_d = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    div_quo_d = {work_q[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      of_q    <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (M == OP_MULU) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= '0;
              work_q  <= A;
              opnd_q  <= B;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (M == OP_DIVU && B != '0) begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= '0;
              work_q  <= A;
              opnd_q  <= B;
            end
`endif
            else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              lo_q    <= alu_lo_d;
              hi_q    <= alu_hi_d;
              zero_q  <= alu_zero_d;
              of_q    <= alu_of_d;
              dz_q    <= alu_dz_d;
              ill_q   <= alu_ill_d;
            end
          end
        end
        S_MUL: begin
          acc_q  <= mul_hi_d;
          work_q <= mul_lo_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lo_q    <= mul_lo_d;
            hi_q    <= mul_hi_d;
            zero_q  <= (mul_lo_d == '0);
            of_q    <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          acc_q  <= div_rem_d;
          work_q <= div_quo_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lo_q    <= div_quo_d;
            hi_q    <= div_rem_d;
            zero_q  <= (div_quo_d == '0);
            of_q    <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign LO   = lo_q;
  assign HI   = hi_q;
  assign ZERO = zero_q;
  assign OF   = of_q;
  assign DZ   = dz_q;
  assign ILL  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: scoreboard of expected results, one task per scenario.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  M = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, ZERO, OF, DZ, ILL;
  logic [31:0] LO, HI;

  logic        start8 = 1'b0;
  logic [3:0]  m8 = 4'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, zero8, of8, dz8, ill8;
  logic [7:0]  lo8, hi8;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        of;
    logic        dz;
    logic        ill;
    logic        bsy;
    logic        bdone;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .A(A), .B(B),
    .busy(busy), .done(done), .LO(LO), .HI(HI),
    .ZERO(ZERO), .OF(OF), .DZ(DZ), .ILL(ILL)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .M(m8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .LO(lo8), .HI(hi8),
    .ZERO(zero8), .OF(of8), .DZ(dz8), .ILL(ill8)
  );

  // Reference model written from the opcode table, using wide arithmetic
  function automatic exp_t model(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e = '0;
    e.lat = 8'd1;
    e.bsy = 1'b1;
    case (m)
      4'd0: e.lo = a & b;
      4'd1: e.lo = a | b;
      4'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.lo = a + b;
        e.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.lo = a - b;
        e.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: e.lo = ~a;
      4'd6: e.lo = ~(a | b);
      4'd7: e.lo = a ^ b;
      4'd8: begin
        p = 64'(a) * 64'(b);
        e.lo = p[31:0];
        e.hi = p[63:32];
        e.lat = 8'd33;
      end
`ifdef SEQ_ALU_DIV_EN
      4'd9: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          e.lat = 8'd33;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.lo == 32'd0) && !e.ill;
    return e;
  endfunction

  // Drive one request from IDLE, scramble inputs after acceptance, wait for done
  task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output exp_t obs);
    int   lat;
    logic allb;
    sb.push_back(model(m, a, b));
    @(negedge clk);
    start = 1'b1; M = m; A = a; B = b;
    @(negedge clk);
    start = 1'b0; M = ~m; A = ~a; B = ~b;
    lat  = 1;
    allb = 1'b1;
    while (done !== 1'b1 && lat < 80) begin
      allb = allb & busy;
      @(negedge clk);
      lat++;
      if (poke) begin start = lat[0]; M = 4'd2; end
    end
    start = 1'b0;
    obs.lo    = LO;
    obs.hi    = HI;
    obs.zero  = ZERO;
    obs.of    = OF;
    obs.dz    = DZ;
    obs.ill   = ILL;
    obs.bsy   = allb;
    obs.bdone = busy;
    obs.lat   = (done === 1'b1) ? 8'(lat) : 8'hFF;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, LO, HI, ZERO, OF, DZ, ILL} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", {busy, done, LO, HI, ZERO, OF, DZ, ILL});
    end
    rst = 1'b0;
    start = 1'b1; M = 4'd2; A = 32'd7; B = 32'd8;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, LO} !== {1'b1, 32'd15}) begin
      errors++;
      $display("FAIL first_start got done=%b lo=%h want done=1 lo=0000000f", done, LO);
    end
  endtask

  task automatic test_logic();
    exp_t o, e;
    for (int i = 0; i < 8; i++) begin
      issue(4'(i), $urandom, $urandom, 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL op%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_arith();
    exp_t o, e;
    logic [3:0]  ms [6] = '{4'd2, 4'd4, 4'd3, 4'd3, 4'd4, 4'd2};
    logic [31:0] as [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] bs [6] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'h8000_0000, 32'd1};
    for (int i = 0; i < 6; i++) begin
      issue(ms[i], as[i], bs[i], 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL arith%0d got=%h want=%h", i, o, e); end
    end
    checks++;
    if ({LO, OF, ZERO, HI} !== {32'd0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL add_wrap got lo=%h of=%b z=%b hi=%h", LO, OF, ZERO, HI);
    end
  endtask

  task automatic test_mul();
    exp_t o, e;
    logic [31:0] as [3] = '{32'hFFFF_FFFF, 32'd0, $urandom};
    logic [31:0] bs [3] = '{32'hFFFF_FFFF, 32'h1234_5678, $urandom};
    for (int i = 0; i < 3; i++) begin
      issue(4'd8, as[i], bs[i], 1'b1, o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL mulu%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_div();
    exp_t o, e;
    logic [31:0] as [5] = '{32'd100, 32'd9, 32'hFFFF_FFFF, 32'd5, $urandom};
    logic [31:0] bs [5] = '{32'd7, 32'd0, 32'd1, 32'd10, 32'd0 + $urandom_range(1, 65535)};
    for (int i = 0; i < 5; i++) begin
      issue(4'd9, as[i], bs[i], 1'b1, o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL divu%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    exp_t o, e;
    logic [3:0] ms [3] = '{4'd12, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      issue(ms[i], $urandom, $urandom, 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL illegal%0d got=%h want=%h", ms[i], o, e); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    issue(4'd7, 32'hA5A5_0F0F, 32'h0FF0_00FF, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL b2b_xor got=%h want=%h", o, e); end
    start = 1'b1; M = 4'd1; A = 32'hFFFF_0000; B = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, LO} !== {1'b0, e.lo}) begin
      errors++;
      $display("FAIL done_start_ignored got done=%b lo=%h want done=0 lo=%h", done, LO, e.lo);
    end
    issue(4'd3, 32'd10, 32'd3, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL b2b_sub got=%h want=%h", o, e); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b want=0", done); end
  endtask

  task automatic test_reset_mid();
    exp_t o, e;
    bit   saw;
    @(negedge clk);
    start = 1'b1; M = 4'd8; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, LO, HI, ZERO, OF, DZ, ILL} !== 70'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h want=0", {busy, done, LO, HI, ZERO, OF, DZ, ILL});
    end
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL reset_no_done got done seen=1 want 0"); end
    issue(4'd2, 32'd2, 32'd3, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL add_after_reset got=%h want=%h", o, e); end
  endtask

  task automatic test_width8();
    logic [7:0] as [2] = '{8'hFF, 8'(12'd0 + $urandom_range(0, 255))};
    logic [7:0] bs [2] = '{8'hFF, 8'(12'd0 + $urandom_range(0, 255))};
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 2; i++) begin
      p = 16'(as[i]) * 16'(bs[i]);
      @(negedge clk);
      start8 = 1'b1; m8 = 4'd8; a8 = as[i]; b8 = bs[i];
      @(negedge clk);
      start8 = 1'b0; a8 = ~as[i]; b8 = 8'h00;
      lat = 1;
      while (done8 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++;
      if ({8'(lat), hi8, lo8} !== {8'd9, p}) begin
        errors++;
        $display("FAIL mulu8_%0d got lat=%0d hi=%h lo=%h want lat=9 hi=%h lo=%h",
                 i, lat, hi8, lo8, p[15:8], p[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
